spi_target_regs: RTL and testbench

// Chip-side SPI target answering the host SPI master: receives 40-bit frames (MSB first) on mosi, framed by cs_b, with spi_sel choosing CONFIG (0) or DAC (1).

---
 rtl/spi_target_regs.sv | 153 +++++++++++++++
 tb/tb_spi_target_regs.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_target_regs.sv
// SPI target with oversampled pins: 40-bit frames either write/read an external
// register file (CONFIG) or deliver a DAC code; miso returns the previous frame's result.
module spi_target_regs #(
  parameter int FRAME_BITS  = 40,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_clk,
  input  logic        cs_b,
  input  logic        mosi,
  input  logic        spi_sel,
  output logic        miso,
  output logic        cfg_wr,
  output logic [6:0]  cfg_addr,
  output logic [31:0] cfg_wdata,
  input  logic [31:0] cfg_rdata,
  output logic [31:0] dac_code,
  output logic        dac_valid,
  output logic        frame_err,
  output logic        busy
);

  // state     | meaning
  // WAIT_IDLE | after reset, wait for cs_b high so a partial frame is dropped
  // IDLE      | waiting for cs_b fall
  // SHIFT     | frame in progress, shifting rx/tx on spi_clk edges
  // COMMIT    | one cycle: decode the received frame and issue strobes
  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT, COMMIT} state_t;

  localparam logic [5:0]            FRAME_CNT = 6'(FRAME_BITS);
  localparam logic [FRAME_BITS-1:0] ERR_RESP  = 40'hFF_DEAD_BEEF;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_q, cs_q, mosi_q, sel_q;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, cs_s, mosi_s, sel_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  logic [FRAME_BITS-1:0]  rx_shift, tx_shift, resp;
  logic [5:0]             bit_cnt;
  logic                   sel_lat;
  logic                   rd_pend;

  // Sync flops reset to 0 so a cs_b held low across reset never looks like a fresh fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q <= '0;
      cs_q   <= '0;
      mosi_q <= '0;
      sel_q  <= '0;
      sclk_d <= 1'b0;
      cs_d   <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], spi_clk};
      cs_q   <= {cs_q[SYNC_STAGES-2:0], cs_b};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
      sel_q  <= {sel_q[SYNC_STAGES-2:0], spi_sel};
      sclk_d <= sclk_q[SYNC_STAGES-1];
      cs_d   <= cs_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_q[SYNC_STAGES-1];
  assign cs_s      = cs_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_q[SYNC_STAGES-1];
  assign sel_s     = sel_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_IDLE: if (cs_s)    state_nxt = IDLE;
      IDLE:      if (cs_fall) state_nxt = SHIFT;
      SHIFT:     if (cs_rise) state_nxt = COMMIT;
      COMMIT:                 state_nxt = IDLE;
      default:                state_nxt = WAIT_IDLE;
    endcase
  end

  assign miso = (state == SHIFT) ? tx_shift[FRAME_BITS-1] : 1'b0;
  assign busy = (state == SHIFT) || (state == COMMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_shift  <= '0;
      tx_shift  <= '0;
      resp      <= '0;
      bit_cnt   <= '0;
      sel_lat   <= 1'b0;
      rd_pend   <= 1'b0;
      cfg_wr    <= 1'b0;
      cfg_addr  <= '0;
      cfg_wdata <= '0;
      dac_code  <= '0;
      dac_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cfg_wr    <= 1'b0;
      dac_valid <= 1'b0;
      frame_err <= 1'b0;
      rd_pend   <= 1'b0;
      // Read data is taken one cycle after cfg_addr moves, giving the reg file a full cycle.
      if (rd_pend) resp <= {1'b1, cfg_addr, cfg_rdata};
      case (state)
        IDLE: begin
          if (cs_fall) begin
            tx_shift <= resp;
            bit_cnt  <= '0;
            sel_lat  <= sel_s;
          end
        end
        SHIFT: begin
          if (sclk_rise) begin
            rx_shift <= {rx_shift[FRAME_BITS-2:0], mosi_s};
            if (bit_cnt != 6'd63) bit_cnt <= bit_cnt + 6'd1;
          end
          if (sclk_fall) tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
        end
        COMMIT: begin
          if (bit_cnt != FRAME_CNT || (sel_lat && rx_shift[FRAME_BITS-1:32] != '0)) begin
            frame_err <= 1'b1;
            resp      <= ERR_RESP;
          end else if (sel_lat) begin
            dac_code  <= rx_shift[31:0];
            dac_valid <= 1'b1;
            resp      <= {8'h00, rx_shift[31:0]};
          end else begin
            cfg_addr <= rx_shift[FRAME_BITS-2:32];
            if (rx_shift[FRAME_BITS-1]) begin
              rd_pend <= 1'b1;
            end else begin
              cfg_wdata <= rx_shift[31:0];
              cfg_wr    <= 1'b1;
              resp      <= {1'b0, rx_shift[FRAME_BITS-2:32], rx_shift[31:0]};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_target_regs.sv
// Bench for spi_target_regs: directed vector table, reset-mid-frame sequence and
// random frames checked against a frame-level reference model.
module tb_spi_target_regs;

  logic        clk = 1'b0;
  logic        rst, spi_clk, cs_b, mosi, spi_sel;
  logic        miso, cfg_wr, dac_valid, frame_err, busy;
  logic [6:0]  cfg_addr;
  logic [31:0] cfg_wdata, cfg_rdata, dac_code;

  spi_target_regs dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .cs_b(cs_b), .mosi(mosi),
    .spi_sel(spi_sel), .miso(miso), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .dac_code(dac_code),
    .dac_valid(dac_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int i);
    return 32'h5A00_0000 + 32'(i) * 32'h0102_0304;
  endfunction

  // External register file driven by the DUT's strobes.
  logic [31:0] rf [128];
  logic        rf_load;
  assign cfg_rdata = rf[cfg_addr];
  always @(posedge clk) begin
    if (rf_load) for (int i = 0; i < 128; i++) rf[i] <= pat(i);
    else if (cfg_wr) rf[cfg_addr] <= cfg_wdata;
  end

  int n_wr = 0, n_val = 0, n_err = 0;
  always @(negedge clk) begin
    if (cfg_wr)    n_wr++;
    if (dac_valid) n_val++;
    if (frame_err) n_err++;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model state: what a correct target would hold after each frame.
  logic [31:0] mregs [128];
  logic [39:0] m_resp;
  logic [6:0]  m_addr;
  logic [31:0] m_wdata, m_dac;

  task automatic model_frame(input logic sel, input int n, input logic [39:0] d,
                             output int e_wr, output int e_val, output int e_err,
                             output logic [39:0] e_miso);
    e_miso = m_resp;
    e_wr = 0; e_val = 0; e_err = 0;
    if (n != 40 || (sel && d[39:32] != 8'h00)) begin
      e_err  = 1;
      m_resp = 40'hFF_DEAD_BEEF;
    end else if (sel) begin
      e_val  = 1;
      m_dac  = d[31:0];
      m_resp = {8'h00, d[31:0]};
    end else begin
      m_addr = d[38:32];
      if (d[39]) begin
        m_resp = {1'b1, d[38:32], mregs[d[38:32]]};
      end else begin
        e_wr = 1;
        m_wdata = d[31:0];
        mregs[d[38:32]] = d[31:0];
        m_resp = {1'b0, d[38:32], d[31:0]};
      end
    end
  endtask

  // Master at clk = 4x spi_clk; miso is sampled at the end of each high phase.
  task automatic do_frame(input logic sel, input int n, input logic [39:0] d,
                          input int rst_at, output logic [39:0] got, output logic busy_mid);
    got = '0;
    busy_mid = 1'b0;
    @(negedge clk); spi_sel = sel;
    @(negedge clk); cs_b = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) begin
        rst = 1'b1; repeat (2) @(negedge clk);
        rst = 1'b0; repeat (2) @(negedge clk);
      end
      mosi = (i < 40) ? d[39-i] : 1'b0;
      repeat (2) @(negedge clk);
      spi_clk = 1'b1;
      repeat (2) @(negedge clk);
      if (i < 40) got[39-i] = miso;
      if (i == 20) busy_mid = busy;
      spi_clk = 1'b0;
    end
    repeat (2) @(negedge clk);
    cs_b = 1'b1;
    mosi = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input int n, input logic [39:0] got,
                             input logic [39:0] e_miso, input int d_wr, input int e_wr,
                             input int d_val, input int e_val, input int d_err,
                             input int e_err, input logic busy_mid);
    int sh;
    sh = (n < 40) ? 40 - n : 0;
    chk({tag, " miso"}, 64'(got >> sh), 64'(e_miso >> sh));
    chk({tag, " cfg_wr pulses"}, 64'(d_wr), 64'(e_wr));
    chk({tag, " dac_valid pulses"}, 64'(d_val), 64'(e_val));
    chk({tag, " frame_err pulses"}, 64'(d_err), 64'(e_err));
    chk({tag, " busy mid"}, 64'(busy_mid), 64'(1));
    chk({tag, " busy after"}, 64'(busy), 64'(0));
    chk({tag, " cfg_addr"}, 64'(cfg_addr), 64'(m_addr));
    chk({tag, " cfg_wdata"}, 64'(cfg_wdata), 64'(m_wdata));
    chk({tag, " dac_code"}, 64'(dac_code), 64'(m_dac));
  endtask

  typedef struct {
    logic        sel;
    int          n;
    logic [39:0] d;
    logic [39:0] exp_miso;
    int          exp_wr, exp_val, exp_err;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [39:0] got, e_miso, d;
    logic        bm, sel;
    int          e_wr, e_val, e_err, w0, v0, r0, n;

    vecs[0] = '{1'b0, 40, {1'b0, 7'h05, 32'h1234_5678}, 40'h00_0000_0000, 1, 0, 0};
    vecs[1] = '{1'b0, 40, {1'b0, 7'h05, 32'hCAFE_0001}, 40'h05_1234_5678, 1, 0, 0};
    vecs[2] = '{1'b0, 40, {1'b1, 7'h05, 32'h0000_0000}, 40'h05_CAFE_0001, 0, 0, 0};
    vecs[3] = '{1'b1, 40, 40'h00_0000_ABCD,             40'h85_CAFE_0001, 0, 1, 0};
    vecs[4] = '{1'b0, 39, {1'b0, 7'h0A, 32'h1111_1111}, 40'h00_0000_ABCD, 0, 0, 1};
    vecs[5] = '{1'b1, 41, 40'h00_0000_1234,             40'hFF_DEAD_BEEF, 0, 0, 1};
    vecs[6] = '{1'b1, 40, 40'h01_0000_5555,             40'hFF_DEAD_BEEF, 0, 0, 1};
    vecs[7] = '{1'b0, 40, {1'b0, 7'h7F, 32'hA5A5_A5A5}, 40'hFF_DEAD_BEEF, 1, 0, 0};

    for (int i = 0; i < 128; i++) mregs[i] = pat(i);
    m_resp = '0; m_addr = '0; m_wdata = '0; m_dac = '0;

    rst = 1'b1; spi_clk = 1'b0; cs_b = 1'b1; mosi = 1'b0; spi_sel = 1'b0; rf_load = 1'b1;
    repeat (3) @(negedge clk);
    rf_load = 1'b0;
    chk("reset miso", 64'(miso), 64'(0));
    chk("reset cfg_wr", 64'(cfg_wr), 64'(0));
    chk("reset cfg_addr", 64'(cfg_addr), 64'(0));
    chk("reset cfg_wdata", 64'(cfg_wdata), 64'(0));
    chk("reset dac_code", 64'(dac_code), 64'(0));
    chk("reset dac_valid", 64'(dac_valid), 64'(0));
    chk("reset frame_err", 64'(frame_err), 64'(0));
    chk("reset busy", 64'(busy), 64'(0));
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      w0 = n_wr; v0 = n_val; r0 = n_err;
      model_frame(vecs[v].sel, vecs[v].n, vecs[v].d, e_wr, e_val, e_err, e_miso);
      do_frame(vecs[v].sel, vecs[v].n, vecs[v].d, -1, got, bm);
      check_frame($sformatf("vec%0d", v), vecs[v].n, got, vecs[v].exp_miso,
                  n_wr - w0, vecs[v].exp_wr, n_val - v0, vecs[v].exp_val,
                  n_err - r0, vecs[v].exp_err, bm);
    end

    // Reset lands at bit 20 of a write; cs_b stays low through the release.
    w0 = n_wr; v0 = n_val; r0 = n_err;
    do_frame(1'b0, 40, {1'b0, 7'h11, 32'hDEAD_0011}, 20, got, bm);
    m_resp = '0; m_addr = '0; m_wdata = '0; m_dac = '0;
    chk("rst-mid cfg_wr pulses", 64'(n_wr - w0), 64'(0));
    chk("rst-mid dac_valid pulses", 64'(n_val - v0), 64'(0));
    chk("rst-mid frame_err pulses", 64'(n_err - r0), 64'(0));
    chk("rst-mid cfg_addr", 64'(cfg_addr), 64'(0));
    w0 = n_wr; v0 = n_val; r0 = n_err;
    d = {1'b0, 7'h22, 32'h0BAD_F00D};
    model_frame(1'b0, 40, d, e_wr, e_val, e_err, e_miso);
    do_frame(1'b0, 40, d, -1, got, bm);
    check_frame("post-rst", 40, got, e_miso, n_wr - w0, e_wr, n_val - v0, e_val,
                n_err - r0, e_err, bm);

    for (int k = 0; k < 40; k++) begin
      sel = 1'($urandom);
      if (sel)
        d = {(($urandom % 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00, 32'($urandom)};
      else
        d = {1'($urandom), 7'($urandom_range(0, 15)), 32'($urandom)};
      case ($urandom % 8)
        0:       n = 39;
        1:       n = 41;
        default: n = 40;
      endcase
      w0 = n_wr; v0 = n_val; r0 = n_err;
      model_frame(sel, n, d, e_wr, e_val, e_err, e_miso);
      do_frame(sel, n, d, -1, got, bm);
      check_frame($sformatf("rnd%0d", k), n, got, e_miso, n_wr - w0, e_wr,
                  n_val - v0, e_val, n_err - r0, e_err, bm);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
